// File: rtl/spi_mem_arb.sv
// spi_mem_arb: round-robin arbiter sharing one synchronous-read memory
// between an SPI-side (s_*) and a host-side (h_*) requester.
// Ports: clk, reset_n (async, active-low); s_/h_ req/we/addr/wdata in,
// ack/rdata out; mem_en/we/addr/wdata out, mem_rdata in;
// conflict_cnt out, conflict_clr in; s_err out.
// Option: SPI_MEM_ARB_WRPROT_EN drops SPI writes to 0x60-0x7F.
module spi_mem_arb #(
  parameter int AW = 7,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_req,
  input  logic          s_we,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_wdata,
  output logic          s_ack,
  output logic [DW-1:0] s_rdata,
  output logic          s_err,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_ack,
  output logic [DW-1:0] h_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [7:0]    conflict_cnt,
  input  logic          conflict_clr
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic          gnt_h_q, gnt_h_d;
  logic          last_h_q, last_h_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          prot_q, prot_d;
  logic [DW-1:0] s_rdata_q, s_rdata_d;
  logic [DW-1:0] h_rdata_q, h_rdata_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          any_req;
  logic          both_req;
  logic          pick_h;
  logic          prot_hit;
  logic [DW-1:0] rsp_data;

  assign any_req  = s_req | h_req;
  assign both_req = s_req & h_req;
  // on contention the port that did not win last time goes next
  assign pick_h   = both_req ? ~last_h_q : h_req;
  assign rsp_data = we_q ? '0 : mem_rdata;

`ifdef SPI_MEM_ARB_WRPROT_EN
  logic [31:0] s_addr_w;
  assign s_addr_w = 32'(s_addr);
  assign prot_hit = ~pick_h & s_we &
                    (s_addr_w >= 32'h60) &
                    (s_addr_w <= 32'h7F);
`else
  assign prot_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_h_d   = gnt_h_q;
    last_h_d  = last_h_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    prot_d    = prot_q;
    s_rdata_d = s_rdata_q;
    h_rdata_d = h_rdata_q;
    cnt_d     = cnt_q;
    if (state_q == IDLE && any_req) begin
      gnt_h_d  = pick_h;
      last_h_d = pick_h;
      we_d     = pick_h ? h_we : s_we;
      addr_d   = pick_h ? h_addr : s_addr;
      wdata_d  = pick_h ? h_wdata : s_wdata;
      prot_d   = prot_hit;
    end
    if (state_q == IDLE && both_req &&
        cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (conflict_clr) begin
      cnt_d = '0;
    end
    // keep the response word so rdata holds after ack drops
    if (state_q == RESP) begin
      if (gnt_h_q) h_rdata_d = rsp_data;
      else         s_rdata_d = rsp_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_h_q   <= 1'b0;
      last_h_q  <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      prot_q    <= 1'b0;
      s_rdata_q <= '0;
      h_rdata_q <= '0;
      cnt_q     <= '0;
    end else begin
      gnt_h_q   <= gnt_h_d;
      last_h_q  <= last_h_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      prot_q    <= prot_d;
      s_rdata_q <= s_rdata_d;
      h_rdata_q <= h_rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    s_ack   = 1'b0;
    h_ack   = 1'b0;
    s_err   = 1'b0;
    s_rdata = s_rdata_q;
    h_rdata = h_rdata_q;
    unique case (state_q)
      ACCESS: begin
        mem_en = 1'b1;
        // a protected write still strobes mem_en but never writes
        mem_we = we_q & ~prot_q;
      end
      RESP: begin
        s_ack = ~gnt_h_q;
        h_ack = gnt_h_q;
        s_err = ~gnt_h_q & prot_q;
        if (gnt_h_q) h_rdata = rsp_data;
        else         s_rdata = rsp_data;
      end
      default: ;
    endcase
  end

  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_spi_mem_arb.sv
// tb_spi_mem_arb: directed and random stimulus for spi_mem_arb,
// checked against a transaction-level reference model.
module tb_spi_mem_arb;

`ifdef SPI_MEM_ARB_WRPROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        s_req, s_we, s_ack, s_err;
  logic [6:0]  s_addr;
  logic [15:0] s_wdata, s_rdata;
  logic        h_req, h_we, h_ack;
  logic [6:0]  h_addr;
  logic [15:0] h_wdata, h_rdata;
  logic        mem_en, mem_we;
  logic [6:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [7:0]  conflict_cnt;
  logic        conflict_clr;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [128] = '{default: 16'h0};
  logic [15:0] ref_mem [128] = '{default: 16'h0};
  bit          m_last_h;
  int          m_cnt;
  logic [15:0] m_s_rd;
  logic [15:0] m_h_rd;

  spi_mem_arb #(.AW(7), .DW(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_ack(s_ack), .s_rdata(s_rdata),
    .s_err(s_err),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_ack(h_ack), .h_rdata(h_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt), .conflict_clr(conflict_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_h = 1'b1;
    m_cnt    = 0;
    m_s_rd   = '0;
    m_h_rd   = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, 32'({s_ack, h_ack}), 32'(0));
    chk({tag, "_mem"}, 32'({mem_en, mem_we}), 32'(0));
    chk({tag, "_err"}, 32'(s_err), 32'(0));
  endtask

  // Start at a cycle where the DUT is idle and at least one req is up.
  task automatic one_access(input bit drop_early, input bit hold,
                            output bit g_h);
    bit          we;
    bit          prot;
    logic [6:0]  a;
    logic [15:0] d;
    logic [15:0] rd;
    g_h  = (s_req && h_req) ? !m_last_h : h_req;
    we   = g_h ? h_we : s_we;
    a    = g_h ? h_addr : s_addr;
    d    = g_h ? h_wdata : s_wdata;
    prot = PROT_EN && !g_h && we && (a >= 7'h60);
    if (conflict_clr) m_cnt = 0;
    else if (s_req && h_req && m_cnt < 255) m_cnt++;
    m_last_h = g_h;
    cyc();
    conflict_clr = 1'b0;
    chk("acc_en", 32'(mem_en), 32'(1));
    chk("acc_we", 32'(mem_we), 32'(we && !prot));
    chk("acc_addr", 32'(mem_addr), 32'(a));
    chk("acc_wdata", 32'(mem_wdata), 32'(d));
    chk("acc_ack", 32'({s_ack, h_ack}), 32'(0));
    chk("acc_cnt", 32'(conflict_cnt), 32'(m_cnt));
    if (drop_early) begin
      if (g_h) h_req = 1'b0;
      else     s_req = 1'b0;
    end
    rd = we ? 16'h0 : ref_mem[a];
    if (we && !prot) ref_mem[a] = d;
    if (g_h) m_h_rd = rd;
    else     m_s_rd = rd;
    cyc();
    chk("rsp_mem", 32'({mem_en, mem_we}), 32'(0));
    chk("rsp_s_ack", 32'(s_ack), 32'(!g_h));
    chk("rsp_h_ack", 32'(h_ack), 32'(g_h));
    chk("rsp_s_err", 32'(s_err), 32'(prot));
    chk("rsp_s_rdata", 32'(s_rdata), 32'(m_s_rd));
    chk("rsp_h_rdata", 32'(h_rdata), 32'(m_h_rd));
    if (!hold) begin
      if (g_h) h_req = 1'b0;
      else     s_req = 1'b0;
    end
    cyc();
    chk_quiet("idle");
    chk("idle_s_rdata", 32'(s_rdata), 32'(m_s_rd));
    chk("idle_h_rdata", 32'(h_rdata), 32'(m_h_rd));
  endtask

  task automatic set_s(input bit we, input logic [6:0] a,
                       input logic [15:0] d);
    s_req = 1'b1; s_we = we; s_addr = a; s_wdata = d;
  endtask

  task automatic set_h(input bit we, input logic [6:0] a,
                       input logic [15:0] d);
    h_req = 1'b1; h_we = we; h_addr = a; h_wdata = d;
  endtask

  initial begin
    bit g;
    bit exp_order [4];
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
    reset_n = 1'b0;
    s_req = 0; s_we = 0; s_addr = '0; s_wdata = '0;
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    conflict_clr = 1'b0;
    model_reset();
    #2;
    chk_quiet("rst");
    chk("rst_addr", 32'(mem_addr), 32'(0));
    chk("rst_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_s_rdata", 32'(s_rdata), 32'(0));
    chk("rst_h_rdata", 32'(h_rdata), 32'(0));
    chk("rst_cnt", 32'(conflict_cnt), 32'(0));
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    chk_quiet("post_rst");

    // single SPI write
    set_s(1'b1, 7'h05, 16'hA5A5);
    one_access(1'b0, 1'b0, g);
    chk("w05_mem", 32'(mem[7'h05]), 32'(16'hA5A5));

    // host write then host read of 0x10
    set_h(1'b1, 7'h10, 16'h1234);
    one_access(1'b0, 1'b0, g);
    set_h(1'b0, 7'h10, 16'h0);
    one_access(1'b0, 1'b0, g);
    chk("h_read_1234", 32'(h_rdata), 32'(16'h1234));

    // req dropped right after grant still completes
    set_s(1'b0, 7'h05, 16'h0);
    one_access(1'b1, 1'b0, g);
    chk("s_read_a5a5", 32'(s_rdata), 32'(16'hA5A5));

    // protected region behaviour
    set_s(1'b1, 7'h7F, 16'hFFFF);
    one_access(1'b0, 1'b0, g);
    set_h(1'b1, 7'h7F, 16'h0BEE);
    one_access(1'b0, 1'b0, g);
    chk("h_w7f_mem", 32'(mem[7'h7F]), 32'(16'h0BEE));
    set_s(1'b0, 7'h7F, 16'h0);
    one_access(1'b0, 1'b0, g);

    // fresh reset, both held for four transactions
    reset_n = 1'b0;
    model_reset();
    cyc();
    reset_n = 1'b1;
    cyc();
    set_s(1'b1, 7'h20, 16'h5555);
    set_h(1'b0, 7'h20, 16'h0);
    for (int i = 0; i < 4; i++) begin
      one_access(1'b0, 1'b1, g);
      chk("rr_order", 32'(g), 32'(exp_order[i]));
    end
    s_req = 1'b0;
    h_req = 1'b0;
    cyc();
    chk("rr_cnt4", 32'(conflict_cnt), 32'(4));
    chk_quiet("rr_idle");

    // saturation over 300 contended idle cycles, then clear
    set_s(1'b0, 7'h21, 16'h0);
    set_h(1'b1, 7'h22, 16'h7777);
    for (int i = 0; i < 300; i++) one_access(1'b0, 1'b1, g);
    chk("sat_ff", 32'(conflict_cnt), 32'(8'hFF));
    conflict_clr = 1'b1;
    one_access(1'b0, 1'b0, g);
    chk("clr_zero", 32'(conflict_cnt), 32'(0));
    s_req = 1'b0;
    h_req = 1'b0;
    cyc();
    cyc();
    chk("clr_hold", 32'(conflict_cnt), 32'(0));

    // random traffic
    for (int i = 0; i < 60; i++) begin
      if (!s_req && $urandom_range(1) == 1)
        set_s(1'($urandom_range(1)), 7'($urandom), 16'($urandom));
      if (!h_req && $urandom_range(1) == 1)
        set_h(1'($urandom_range(1)), 7'($urandom), 16'($urandom));
      if (!s_req && !h_req)
        set_s(1'($urandom_range(1)), 7'($urandom), 16'($urandom));
      one_access(1'($urandom_range(3) == 0), 1'b0, g);
    end
    while (s_req || h_req) one_access(1'b0, 1'b0, g);

    // reset during the access cycle aborts it
    set_h(1'b0, 7'h10, 16'h0);
    cyc();
    chk("abort_en", 32'(mem_en), 32'(1));
    reset_n = 1'b0;
    #1;
    h_req = 1'b0;
    model_reset();
    chk_quiet("abort_rst");
    chk("abort_addr", 32'(mem_addr), 32'(0));
    chk("abort_h_rdata", 32'(h_rdata), 32'(0));
    chk("abort_cnt", 32'(conflict_cnt), 32'(0));
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_quiet("abort_after");
    end

    // SPI wins first contention after reset
    set_s(1'b0, 7'h05, 16'h0);
    set_h(1'b0, 7'h10, 16'h0);
    one_access(1'b0, 1'b0, g);
    chk("first_win_spi", 32'(g), 32'(0));
    one_access(1'b0, 1'b0, g);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mem_arb.md
SPI_MEM_ARB -- requirements
Module: spi_mem_arb

Interface
REQ-001 Parameter AW, default 7, memory address width.
REQ-002 Parameter DW, default 16, memory data width.
REQ-003 clk  input  1  block clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 s_req  input  1  SPI-side requester access request, held until s_ack.
REQ-006 s_we  input  1  SPI-side write enable (1 write, 0 read), stable while s_req.
REQ-007 s_addr  input  AW  SPI-side address, stable while s_req.
REQ-008 s_wdata  input  DW  SPI-side write data, stable while s_req.
REQ-009 s_ack  output  1  SPI-side completion, one-cycle pulse.
REQ-010 s_rdata  output  DW  SPI-side read data, valid while s_ack high.
REQ-011 h_req, h_we, h_addr, h_wdata, h_ack, h_rdata: host-side port, same directions, widths and meanings as s_*.
REQ-012 mem_en  output  1  memory access strobe.
REQ-013 mem_we  output  1  memory write strobe, qualified by mem_en.
REQ-014 mem_addr  output  AW; mem_wdata  output  DW; mem_rdata  input  DW, synchronous read, valid the cycle after mem_en.
REQ-015 conflict_cnt  output  8  saturating count of contended arbitration cycles.
REQ-016 conflict_clr  input  1  synchronous clear of conflict_cnt.
REQ-017 s_err  output  1  one-cycle pulse on a dropped protected write (macro only, else tied 0).

Function
REQ-018 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req sampled high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-019 In IDLE with exactly one req high, that port is granted; with both high, the port not granted last is granted (round-robin).
REQ-020 Granted port's we/addr/wdata are registered at the IDLE->ACCESS edge; mem_en=1, mem_we=granted we, mem_addr/mem_wdata=registered values for exactly the ACCESS cycle.
REQ-021 In RESP, granted port's ack=1 for one cycle and rdata=mem_rdata for reads; rdata of a write response is 0.
REQ-022 Latency: req sampled at edge N -> mem_en high cycle N+1 -> ack high cycle N+2; max throughput one access per 3 cycles.
REQ-023 Req high in IDLE after a RESP is a new request; requesters deassert req on the edge ack is seen.
REQ-024 Req deasserted after grant: access still completes and ack still pulses.
REQ-025 Non-granted ack, mem_en, mem_we are 0 outside the states above; rdata outputs hold last value.
REQ-026 conflict_cnt increments by 1 on each IDLE cycle with s_req and h_req both high, holds at 0xFF; conflict_clr wins over simultaneous increment.
REQ-027 Last-grant flag updates only on grant; no grant occurs in ACCESS or RESP.

Reset
REQ-028 On reset_n low, immediately: state IDLE, all acks 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, s_rdata/h_rdata 0, conflict_cnt 0, s_err 0, last-grant=host (SPI wins first contention).
REQ-029 Reset mid-access aborts it; no ack is issued for the aborted access after reset release.

Configuration
REQ-030 Macro SPI_MEM_ARB_WRPROT_EN: defined -> SPI-side writes to addresses 0x60-0x7F run the normal timing with mem_en=1, mem_we=0, and s_err pulses with s_ack; host writes are unaffected.
REQ-031 Without SPI_MEM_ARB_WRPROT_EN: all writes reach memory, s_err constant 0.

Verification
REQ-032 Single SPI write: s_req, s_we=1, s_addr=0x05, s_wdata=0xA5A5 -> mem_en/mem_we high next cycle with addr 0x05, data 0xA5A5; s_ack cycle after.
REQ-033 Host read: mem holds 0x1234 at 0x10, h_req read 0x10 -> h_ack at N+2 with h_rdata=0x1234.
REQ-034 Both req held continuously for 4 transactions after reset -> grant order S,H,S,H; conflict_cnt=4.
REQ-035 300 contended IDLE cycles -> conflict_cnt=0xFF; conflict_clr pulse -> 0x00 next cycle.
REQ-036 reset_n low during ACCESS -> mem_en, acks 0 immediately; after release, state IDLE, no ack.
REQ-037 With SPI_MEM_ARB_WRPROT_EN, SPI write 0x7F/0xFFFF -> mem_we=0, s_ack and s_err pulse together; host write 0x7F -> mem_we=1.
